// File: rtl/simon_pkg.sv
// Shared constants and types for the SIMON 128/192 input loader.
// Default build is plain ECB feeding; define SIMON_LOADER_CBC_EN for chaining.
package simon_pkg;
   localparam int SIMON_N = 64;
   localparam int SIMON_M = 3;
   localparam int SIMON_W = 32;
   localparam int WPB     = 2 * SIMON_N / SIMON_W;
   localparam int WPK     = SIMON_M * SIMON_N / SIMON_W;

   typedef enum logic [1:0] {IDLE, OFFER, RELEASE} data_state_e;

   typedef logic [1:0][SIMON_N-1:0] block_t;
endpackage

// File: rtl/simon_block_fifo2.sv
// Two-entry block buffer; slot0 is always the head, entries shift on pop.
module simon_block_fifo2 #(
   parameter int BW = 128
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  logic [BW-1:0] push_data_i,
   input  logic          pop_i,
   output logic [BW-1:0] head_o,
   output logic [1:0]    count_o
);
   logic [BW-1:0] slot0_q, slot1_q;
   logic [1:0]    count_q;
   logic          push_ok, pop_ok;

   assign pop_ok  = pop_i & (count_q != 2'd0);
   assign push_ok = push_i & ((count_q != 2'd2) | pop_ok);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot0_q <= '0;
         slot1_q <= '0;
         count_q <= 2'd0;
      end else begin
         case ({push_ok, pop_ok})
            2'b10: begin
               if (count_q == 2'd0) slot0_q <= push_data_i;
               else                 slot1_q <= push_data_i;
               count_q <= count_q + 2'd1;
            end
            2'b01: begin
               slot0_q <= slot1_q;
               count_q <= count_q - 2'd1;
            end
            2'b11: begin
               // simultaneous push/pop keeps the count; new block lands behind the survivor
               if (count_q == 2'd1) begin
                  slot0_q <= push_data_i;
               end else begin
                  slot0_q <= slot1_q;
                  slot1_q <= push_data_i;
               end
            end
            default: ;
         endcase
      end
   end

   assign head_o  = slot0_q;
   assign count_o = count_q;
endmodule

// File: rtl/simon_input_loader.sv
// Assembles host words into SIMON blocks/keys and runs the core handshakes.
// Optional macro SIMON_LOADER_CBC_EN adds CBC chaining (enc_dec/doneData/outData).
module simon_input_loader
   import simon_pkg::*;
#(
   parameter int N = SIMON_N,
   parameter int M = SIMON_M,
   parameter int W = SIMON_W
) (
   input  logic                clk,
   input  logic                R,
   input  logic                flush,
   input  logic [W-1:0]        wrData,
   input  logic                wrValid,
   input  logic                wrKey,
   output logic                wrReady,
   output logic                newData,
   output logic [1:0][N-1:0]   inData,
   input  logic                loadData,
   output logic                newKey,
   output logic [M-1:0][N-1:0] key,
   input  logic                loadKey,
   output logic [1:0]          pending
`ifdef SIMON_LOADER_CBC_EN
   ,
   input  logic                enc_dec,
   input  logic                doneData,
   input  logic [1:0][N-1:0]   outData
`endif
);
   localparam int BW    = 2 * N;
   localparam int KW    = M * N;
   localparam int WPB_L = BW / W;
   localparam int WPK_L = KW / W;
   localparam int DCW   = $clog2(WPB_L);
   localparam int KCW   = $clog2(WPK_L);

   logic [BW-W-1:0] dsr_q;
   logic [KW-W-1:0] ksr_q;
   logic [KW-1:0]   key_q;
   logic [DCW-1:0]  dc_q;
   logic [KCW-1:0]  kc_q;
   logic            new_key_q, new_data_q;
   data_state_e     state_q;

   logic [BW-1:0]   block_d, head;
   logic [KW-1:0]   key_d;
   logic [1:0]      count;
   logic            data_acc, key_acc, push, pop, chain_ok;

   assign wrReady  = ~R & (wrKey ? ~new_key_q : (count != 2'd2));
   assign data_acc = wrValid & wrReady & ~wrKey & ~flush;
   assign key_acc  = wrValid & wrReady &  wrKey & ~flush;
   assign block_d  = {dsr_q, wrData};
   assign key_d    = {ksr_q, wrData};
   assign push     = data_acc & (dc_q == DCW'(WPB_L - 1));
   assign pop      = (state_q == OFFER) & loadData;

   simon_block_fifo2 #(.BW(BW)) u_fifo (
      .clk         (clk),
      .rst         (R),
      .push_i      (push),
      .push_data_i (block_d),
      .pop_i       (pop),
      .head_o      (head),
      .count_o     (count)
   );

   always_ff @(posedge clk or posedge R) begin
      if (R) begin
         dsr_q     <= '0;
         ksr_q     <= '0;
         key_q     <= '0;
         dc_q      <= '0;
         kc_q      <= '0;
         new_key_q <= 1'b0;
      end else begin
         if (flush) begin
            dc_q <= '0;
            kc_q <= '0;
         end
         if (data_acc) begin
            dsr_q <= block_d[BW-W-1:0];
            dc_q  <= push ? '0 : dc_q + 1'b1;
         end
         if (key_acc) begin
            ksr_q <= key_d[KW-W-1:0];
            if (kc_q == KCW'(WPK_L - 1)) begin
               kc_q      <= '0;
               key_q     <= key_d;
               new_key_q <= 1'b1;
            end else begin
               kc_q <= kc_q + 1'b1;
            end
         end
         if (new_key_q & loadKey) new_key_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge R) begin
      if (R) begin
         state_q    <= IDLE;
         new_data_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if ((count != 2'd0) && chain_ok) begin
               state_q    <= OFFER;
               new_data_q <= 1'b1;
            end
            OFFER: if (loadData) begin
               state_q    <= RELEASE;
               new_data_q <= 1'b0;
            end
            RELEASE: if (!loadData) state_q <= IDLE;
            default: begin
               state_q    <= IDLE;
               new_data_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef SIMON_LOADER_CBC_EN
   logic [BW-1:0] chain_q;
   logic          chain_valid_q, done_q;

   assign chain_ok = ~enc_dec | chain_valid_q;

   always_ff @(posedge clk or posedge R) begin
      if (R) begin
         chain_q       <= '0;
         chain_valid_q <= 1'b1;
         done_q        <= 1'b0;
      end else begin
         done_q <= doneData;
         if (pop) chain_valid_q <= 1'b0;
         if (doneData & ~done_q) begin
            chain_q       <= outData;
            chain_valid_q <= 1'b1;
         end
         // flush restarts the chain from the zero IV
         if (flush) begin
            chain_q       <= '0;
            chain_valid_q <= 1'b1;
         end
      end
   end
`else
   assign chain_ok = 1'b1;
`endif

   for (genvar gi = 0; gi < 2; gi++) begin : g_half
`ifdef SIMON_LOADER_CBC_EN
      assign inData[gi] = enc_dec ? (head[gi*N +: N] ^ chain_q[gi*N +: N]) : head[gi*N +: N];
`else
      assign inData[gi] = head[gi*N +: N];
`endif
   end

   assign newData = new_data_q;
   assign newKey  = new_key_q;
   assign key     = key_q;
   assign pending = count;
endmodule

// File: tb/tb_simon_input_loader.sv
// Directed self-checking bench for simon_input_loader (vector table plus corner sequences).
module tb_simon_input_loader;
   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic [31:0]       wr_data;
   logic              wr_valid, wr_key, wr_ready;
   logic              new_data, load_data, new_key, load_key;
   logic [1:0][63:0]  in_data;
   logic [2:0][63:0]  key;
   logic [1:0]        pending;
`ifdef SIMON_LOADER_CBC_EN
   logic              enc_dec = 1'b0;
   logic              done_data = 1'b0;
   logic [1:0][63:0]  out_data = '0;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   simon_input_loader dut (
      .clk      (clk),
      .R        (rst),
      .flush    (flush),
      .wrData   (wr_data),
      .wrValid  (wr_valid),
      .wrKey    (wr_key),
      .wrReady  (wr_ready),
      .newData  (new_data),
      .inData   (in_data),
      .loadData (load_data),
      .newKey   (new_key),
      .key      (key),
      .loadKey  (load_key),
      .pending  (pending)
`ifdef SIMON_LOADER_CBC_EN
      ,
      .enc_dec  (enc_dec),
      .doneData (done_data),
      .outData  (out_data)
`endif
   );

   typedef struct {
      bit           v, k, ld, lk;
      logic [31:0]  d;
      bit           e_rdy, e_nd, e_nk;
      logic [1:0]   e_pend;
      bit           chk_in;
      logic [127:0] e_in;
      bit           chk_key;
      logic [191:0] e_key;
   } vec_t;

   localparam logic [127:0] BLK1 = 128'h206572656874206E6568772065626972;
   localparam logic [191:0] KEY1 = 192'h17161514131211100F0E0D0C0B0A09080706050403020100;

   task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mkv(bit v, bit k, logic [31:0] d, bit ld, bit lk, bit rdy, bit nd,
                                bit nk, logic [1:0] pd, bit ci, logic [127:0] ei, bit ck);
      vec_t r;
      r.v = v; r.k = k; r.d = d; r.ld = ld; r.lk = lk;
      r.e_rdy = rdy; r.e_nd = nd; r.e_nk = nk; r.e_pend = pd;
      r.chk_in = ci; r.e_in = ei; r.chk_key = ck; r.e_key = KEY1;
      return r;
   endfunction

   task automatic drive_word(input bit k, input logic [31:0] w);
      int n = 0;
      @(negedge clk);
      wr_valid = 1'b1; wr_key = k; wr_data = w;
      #1;
      while (!wr_ready && n < 40) begin
         @(negedge clk); #1; n++;
      end
      chk("word_accept_wait", 192'(wr_ready), 192'(1));
      @(posedge clk); #1;
      wr_valid = 1'b0;
   endtask

   task automatic send_block(input logic [127:0] b);
      for (int i = 0; i < 4; i++) drive_word(1'b0, b[127-32*i -: 32]);
   endtask

   task automatic consume(input logic [127:0] exp, input string nm);
      int n = 0;
      @(negedge clk);
      while (!new_data && n < 40) begin
         @(negedge clk); n++;
      end
      chk({nm, "_newData"}, 192'(new_data), 192'(1));
      chk({nm, "_inData"}, 192'(in_data), 192'(exp));
      load_data = 1'b1;
      @(posedge clk); #1;
      load_data = 1'b0;
      chk({nm, "_drop"}, 192'(new_data), 192'(0));
      $display("consumed %s block %h", nm, in_data);
   endtask

   vec_t vecs[16];

   initial begin
      logic [127:0] ba, bb, bc, bd, be, bf;
      logic [191:0] k2;
      rst = 1'b1; flush = 1'b0; wr_data = '0; wr_valid = 1'b0; wr_key = 1'b0;
      load_data = 1'b0; load_key = 1'b0;

      #3;
      chk("rst_wrReady", 192'(wr_ready), 192'(0));
      chk("rst_newData", 192'(new_data), 192'(0));
      chk("rst_newKey",  192'(new_key),  192'(0));
      chk("rst_pending", 192'(pending),  192'(0));
      chk("rst_inData",  192'(in_data),  192'(0));
      chk("rst_key",     192'(key),      192'(0));
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      vecs[0]  = mkv(1,0,32'h20657265,0,0, 1,0,0,2'd0, 0,'0,0);
      vecs[1]  = mkv(1,0,32'h6874206E,0,0, 1,0,0,2'd0, 0,'0,0);
      vecs[2]  = mkv(1,0,32'h65687720,0,0, 1,0,0,2'd0, 0,'0,0);
      vecs[3]  = mkv(1,0,32'h65626972,0,0, 1,0,0,2'd1, 1,BLK1,0);
      vecs[4]  = mkv(0,0,32'h0,       0,0, 1,1,0,2'd1, 1,BLK1,0);
      vecs[5]  = mkv(0,0,32'h0,       1,0, 1,0,0,2'd0, 0,'0,0);
      vecs[6]  = mkv(0,0,32'h0,       0,0, 1,0,0,2'd0, 0,'0,0);
      vecs[7]  = mkv(1,1,32'h17161514,0,0, 1,0,0,2'd0, 0,'0,0);
      vecs[8]  = mkv(1,1,32'h13121110,0,0, 1,0,0,2'd0, 0,'0,0);
      vecs[9]  = mkv(1,1,32'h0F0E0D0C,0,0, 1,0,0,2'd0, 0,'0,0);
      vecs[10] = mkv(1,1,32'h0B0A0908,0,0, 1,0,0,2'd0, 0,'0,0);
      vecs[11] = mkv(1,1,32'h07060504,0,0, 1,0,0,2'd0, 0,'0,0);
      vecs[12] = mkv(1,1,32'h03020100,0,0, 1,0,1,2'd0, 0,'0,1);
      vecs[13] = mkv(1,1,32'hDEADBEEF,0,0, 0,0,1,2'd0, 0,'0,1);
      vecs[14] = mkv(0,1,32'h0,       0,1, 0,0,0,2'd0, 0,'0,0);
      vecs[15] = mkv(1,1,32'hDEADBEEF,0,0, 1,0,0,2'd0, 0,'0,1);

      foreach (vecs[i]) begin
         @(negedge clk);
         wr_valid = vecs[i].v; wr_key = vecs[i].k; wr_data = vecs[i].d;
         load_data = vecs[i].ld; load_key = vecs[i].lk;
         #1;
         chk($sformatf("vec%0d_wrReady", i), 192'(wr_ready), 192'(vecs[i].e_rdy));
         @(posedge clk); #1;
         chk($sformatf("vec%0d_newData", i), 192'(new_data), 192'(vecs[i].e_nd));
         chk($sformatf("vec%0d_newKey", i),  192'(new_key),  192'(vecs[i].e_nk));
         chk($sformatf("vec%0d_pending", i), 192'(pending),  192'(vecs[i].e_pend));
         if (vecs[i].chk_in)  chk($sformatf("vec%0d_inData", i), 192'(in_data), 192'(vecs[i].e_in));
         if (vecs[i].chk_key) chk($sformatf("vec%0d_key", i),    192'(key),     vecs[i].e_key);
         $display("vec %0d: v=%0b k=%0b d=%h rdy=%0b nd=%0b nk=%0b pend=%0d",
                  i, vecs[i].v, vecs[i].k, vecs[i].d, wr_ready, new_data, new_key, pending);
      end
      @(negedge clk);
      wr_valid = 1'b0; wr_key = 1'b0; load_data = 1'b0; load_key = 1'b0;

      // backpressure: three blocks with the core not loading
      ba = 128'h00000001000000020000000300000004;
      bb = 128'h11111111222222223333333344444444;
      bc = 128'hAAAA0000BBBB0000CCCC0000DDDD0000;
      send_block(ba);
      send_block(bb);
      @(negedge clk);
      wr_valid = 1'b1; wr_key = 1'b0; wr_data = bc[127:96];
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("full_wrReady", 192'(wr_ready), 192'(0));
         chk("full_pending", 192'(pending),  192'(2));
         @(negedge clk);
      end
      chk("full_headA", 192'(in_data), 192'(ba));
      load_data = 1'b1;
      #1;
      chk("full_pop_same_cycle_wrReady", 192'(wr_ready), 192'(0));
      @(posedge clk); #1;
      load_data = 1'b0;
      chk("after_pop_pending", 192'(pending), 192'(1));
      @(negedge clk); #1;
      chk("after_pop_wrReady", 192'(wr_ready), 192'(1));
      @(posedge clk); #1;
      wr_valid = 1'b0;
      for (int i = 1; i < 4; i++) drive_word(1'b0, bc[127-32*i -: 32]);
      chk("bp_pending_BC", 192'(pending), 192'(2));
      consume(bb, "bpB");
      consume(bc, "bpC");
      repeat (3) @(negedge clk);
      chk("bp_empty", 192'(pending), 192'(0));

      // flush: discard partial block, keep buffered one
      bd = 128'h0D0D0D0D1D1D1D1D2D2D2D2D3D3D3D3D;
      be = 128'h0E0E0E0E1E1E1E1E2E2E2E2E3E3E3E3E;
      send_block(bd);
      drive_word(1'b0, 32'hBAD00001);
      drive_word(1'b0, 32'hBAD00002);
      @(negedge clk);
      flush = 1'b1; wr_valid = 1'b1; wr_key = 1'b0; wr_data = 32'hBAD00003;
      @(posedge clk); #1;
      flush = 1'b0; wr_valid = 1'b0;
      chk("flush_keeps_buffered", 192'(in_data), 192'(bd));
      send_block(be);
      chk("flush_pending", 192'(pending), 192'(2));
      consume(bd, "flushD");
      consume(be, "flushE");

      // flush also cleared the key counter left at one word
      k2 = 192'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECFD0D1D2D3D4D5D6D7;
      for (int i = 0; i < 6; i++) drive_word(1'b1, k2[191-32*i -: 32]);
      chk("key2_newKey", 192'(new_key), 192'(1));
      chk("key2_value", 192'(key), k2);
      @(negedge clk);
      load_key = 1'b1;
      @(posedge clk); #1;
      load_key = 1'b0;
      chk("key2_release", 192'(new_key), 192'(0));

      // reset during an offer
      bf = 128'hF0F0F0F0F1F1F1F1F2F2F2F2F3F3F3F3;
      send_block(bf);
      repeat (3) @(negedge clk);
      chk("pre_rst_newData", 192'(new_data), 192'(1));
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_newData", 192'(new_data), 192'(0));
      chk("mid_rst_pending", 192'(pending),  192'(0));
      chk("mid_rst_wrReady", 192'(wr_ready), 192'(0));
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("post_rst_newData", 192'(new_data), 192'(0));
         chk("post_rst_pending", 192'(pending),  192'(0));
      end

`ifdef SIMON_LOADER_CBC_EN
      begin
         logic [127:0] p1, p2, o1;
         p1 = 128'h0123456789ABCDEF0011223344556677;
         p2 = 128'hFEDCBA98765432108899AABBCCDDEEFF;
         o1 = 128'h5A5A5A5AA5A5A5A5C3C3C3C33C3C3C3C;
         enc_dec = 1'b1;
         send_block(p1);
         send_block(p2);
         consume(p1, "cbc1");
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("cbc_hold_newData", 192'(new_data), 192'(0));
            chk("cbc_hold_pending", 192'(pending),  192'(1));
         end
         out_data = o1; done_data = 1'b1;
         @(negedge clk);
         done_data = 1'b0;
         consume(p2 ^ o1, "cbc2");
         enc_dec = 1'b0;
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
      $fatal(1, "watchdog");
   end
endmodule
